// File: rtl/spi_response_buffer.sv
// spi_response_buffer: latches a response packet and serialises header, payload (and optional XOR checksum) over a valid/ready byte stream.
// Define SPI_RESPONSE_CHECKSUM_EN to append a checksum byte after the payload.
module spi_response_buffer #(
  parameter int DATA_BYTES = 8,
  parameter int CNT_W = 4
) (
  input  logic                    sysClk,
  input  logic                    reset,
  input  logic [7:0]              instruction_in,
  input  logic [8*DATA_BYTES-1:0] data_in,
  input  logic [CNT_W-1:0]        byte_count_in,
  input  logic                    response_valid,
  input  logic                    spi_tx_ready,
  output logic [7:0]              spi_tx_byte,
  output logic                    spi_tx_valid,
  output logic                    busy,
  output logic                    overflow_flag,
  output logic                    packet_done
);
  localparam int DW = 8*DATA_BYTES;
`ifdef SPI_RESPONSE_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HEADER, DATA, CHECKSUM, DONE} state_t;
  localparam state_t TAIL = CHECKSUM;
  logic [7:0] csum_q;
`else
  typedef enum logic [2:0] {IDLE, HEADER, DATA, DONE} state_t;
  localparam state_t TAIL = DONE;
`endif
  state_t state, next;
  logic [7:0] instr_q;
  logic [DW-1:0] data_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_clamp;
  logic load, xfer;
  assign cnt_clamp = byte_count_in > CNT_W'(DATA_BYTES) ? CNT_W'(DATA_BYTES) : byte_count_in;
  assign load = state == IDLE && response_valid;
  assign xfer = spi_tx_valid && spi_tx_ready;
  always_ff @(posedge sysClk)
    state <= reset ? IDLE : next;
  always_comb begin
    next = state;
    spi_tx_valid = 1'b0;
    spi_tx_byte = 8'h00;
    busy = state != IDLE;
    packet_done = 1'b0;
    case (state)
      IDLE: next = response_valid ? HEADER : IDLE;
      HEADER: begin
        spi_tx_valid = 1'b1;
        spi_tx_byte = instr_q;
        if (spi_tx_ready) next = cnt_q != '0 ? DATA : TAIL;
      end
      DATA: begin
        spi_tx_valid = 1'b1;
        spi_tx_byte = data_q[DW-1 -: 8];
        if (spi_tx_ready && cnt_q == CNT_W'(1)) next = TAIL;
      end
`ifdef SPI_RESPONSE_CHECKSUM_EN
      CHECKSUM: begin
        spi_tx_valid = 1'b1;
        spi_tx_byte = csum_q;
        if (spi_tx_ready) next = DONE;
      end
`endif
      DONE: begin
        packet_done = 1'b1;
        next = IDLE;
      end
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge sysClk) begin
    if (reset) begin
      instr_q <= '0;
      data_q <= '0;
      cnt_q <= '0;
      overflow_flag <= 1'b0;
    end else begin
      if (response_valid && busy) overflow_flag <= 1'b1;
      if (load) begin
        instr_q <= instruction_in;
        data_q <= data_in;
        cnt_q <= cnt_clamp;
      end else if (xfer && state == DATA) begin
        data_q <= data_q << 8;
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end
`ifdef SPI_RESPONSE_CHECKSUM_EN
  // the checksum byte itself is not folded back into the accumulator
  always_ff @(posedge sysClk)
    csum_q <= (reset || load) ? 8'h00 : (xfer && state != CHECKSUM) ? csum_q ^ spi_tx_byte : csum_q;
`endif
endmodule
